pipe_adder: RTL

PIPE_ADDER -- requirements
Module: pipe_adder

---
 rtl/pipe_adder.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/pipe_adder.sv
// pipe_adder: segmented adder/subtractor, SEG bits per stage, valid/ready with a global stall.
// Define PIPE_ADDER_OVF_EN to add the signed-overflow output o_ovf.
module pipe_adder #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_carry,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry
`ifdef PIPE_ADDER_OVF_EN
  ,
  output logic             o_ovf
`endif
);

  localparam int NSTG  = WIDTH / SEG;
  // Operands only need carrying between stages; keep at least one entry for NSTG == 1.
  localparam int NPIPE = (NSTG > 1) ? NSTG - 1 : 1;

  if (WIDTH % SEG != 0) begin : g_bad_cfg
    $error("pipe_adder: WIDTH must be an integer multiple of SEG");
  end

  logic             advance;

  logic             vld_q [NSTG];
  logic             vld_d [NSTG];
  logic             cry_q [NSTG];
  logic             cry_d [NSTG];
  logic [WIDTH-1:0] sum_q [NSTG];
  logic [WIDTH-1:0] sum_d [NSTG];
  logic [WIDTH-1:0] opa_q [NPIPE];
  logic [WIDTH-1:0] opa_d [NPIPE];
  logic [WIDTH-1:0] opb_q [NPIPE];
  logic [WIDTH-1:0] opb_d [NPIPE];

  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] s_in;
  logic             c_in;
  logic             v_in;
  logic [SEG:0]     seg;

`ifdef PIPE_ADDER_OVF_EN
  logic             ovf_q;
  logic             ovf_d;
`endif

  assign advance = i_ready | ~o_valid;
  assign o_ready = advance;

  // Subtract is folded in at the entry: B is inverted and the borrow becomes carry = ~borrow.
  always_comb begin
    a_in = '0;
    b_in = '0;
    s_in = '0;
    c_in = 1'b0;
    v_in = 1'b0;
    seg  = '0;
`ifdef PIPE_ADDER_OVF_EN
    ovf_d = 1'b0;
`endif
    for (int k = 0; k < NPIPE; k++) begin
      opa_d[k] = '0;
      opb_d[k] = '0;
    end
    for (int k = 0; k < NSTG; k++) begin
      if (k == 0) begin
        a_in = i_a;
        b_in = i_sub ? ~i_b : i_b;
        c_in = i_carry ^ i_sub;
        s_in = '0;
        v_in = i_valid;
      end else begin
        a_in = opa_q[k-1];
        b_in = opb_q[k-1];
        c_in = cry_q[k-1];
        s_in = sum_q[k-1];
        v_in = vld_q[k-1];
      end
      seg = {1'b0, a_in[k*SEG +: SEG]} + {1'b0, b_in[k*SEG +: SEG]} + {{SEG{1'b0}}, c_in};
      vld_d[k] = v_in;
      cry_d[k] = seg[SEG];
      sum_d[k] = s_in;
      sum_d[k][k*SEG +: SEG] = seg[SEG-1:0];
      if (k < NSTG - 1) begin
        opa_d[k] = a_in;
        opb_d[k] = b_in;
      end
`ifdef PIPE_ADDER_OVF_EN
      if (k == NSTG - 1) begin
        ovf_d = (a_in[WIDTH-1] == b_in[WIDTH-1]) && (sum_d[k][WIDTH-1] != a_in[WIDTH-1]);
      end
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NSTG; k++) begin
        vld_q[k] <= 1'b0;
        cry_q[k] <= 1'b0;
        sum_q[k] <= '0;
      end
      for (int k = 0; k < NPIPE; k++) begin
        opa_q[k] <= '0;
        opb_q[k] <= '0;
      end
`ifdef PIPE_ADDER_OVF_EN
      ovf_q <= 1'b0;
`endif
    end else if (advance) begin
      for (int k = 0; k < NSTG; k++) begin
        vld_q[k] <= vld_d[k];
        cry_q[k] <= cry_d[k];
        sum_q[k] <= sum_d[k];
      end
      for (int k = 0; k < NPIPE; k++) begin
        opa_q[k] <= opa_d[k];
        opb_q[k] <= opb_d[k];
      end
`ifdef PIPE_ADDER_OVF_EN
      ovf_q <= ovf_d;
`endif
    end
  end

  assign o_valid = vld_q[NSTG-1];
  assign o_sum   = sum_q[NSTG-1];
  assign o_carry = cry_q[NSTG-1];
`ifdef PIPE_ADDER_OVF_EN
  assign o_ovf   = ovf_q;
`endif

endmodule
